// File: rtl/inst_buffer_pkg.sv
// Shared constants and default parameters for the instruction buffer between fetch and decode.
// Optional empty-bypass path is enabled by defining INST_BUFFER_BYPASS_EN (see inst_buffer.sv).
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef InstBufDepth
`define InstBufDepth 16
`endif
`ifndef InstBufPtrWidth
`define InstBufPtrWidth 4
`endif

package inst_buffer_pkg;
  localparam int unsigned IB_DEPTH        = `InstBufDepth;
  localparam int unsigned IB_PTR_W        = `InstBufPtrWidth;
  localparam int unsigned IB_INST_W       = `IDWidth;
  localparam int unsigned IB_PC_W         = `AddressWidth;
  localparam int unsigned IB_AFULL_THRESH = 12;
endpackage

// File: rtl/inst_buffer_mem.sv
// Instruction buffer storage: synchronous write, asynchronous read, no reset.
module inst_buffer_mem
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH,
  parameter int unsigned PTR_W = IB_PTR_W,
  parameter int unsigned WIDTH = IB_INST_W + IB_PC_W
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_buffer.sv
// Parametrised fetch-to-decode instruction buffer with registered flags and decoder stream.
// Define INST_BUFFER_BYPASS_EN to forward an enqueue into an empty buffer straight to the output.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH        = IB_DEPTH,
  parameter int unsigned PTR_W        = IB_PTR_W,
  parameter int unsigned INST_W       = IB_INST_W,
  parameter int unsigned PC_W         = IB_PC_W,
  parameter int unsigned AFULL_THRESH = IB_AFULL_THRESH
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              if_en_in,
  input  logic [INST_W-1:0] if_inst_in,
  input  logic [PC_W-1:0]   if_pc_in,
  output logic              full_out,
  output logic              almost_full_out,
  output logic [PTR_W:0]    count_out,
  input  logic              dn_rdy_in,
  output logic              dec_en_out,
  output logic [INST_W-1:0] dec_inst_out,
  output logic [PC_W-1:0]   dec_pc_out
);

  localparam int unsigned ENT_W = INST_W + PC_W;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head, tail, head_nxt, tail_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              full_nxt, afull_nxt, dec_en_nxt;
  logic [INST_W-1:0] dec_inst_nxt;
  logic [PC_W-1:0]   dec_pc_nxt;
  logic              enq, deq, bypass, wr_en;
  logic [ENT_W-1:0]  rd_data;

  inst_buffer_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk     (clk_in),
    .wr_en   (wr_en),
    .wr_addr (tail),
    .wr_data ({if_inst_in, if_pc_in}),
    .rd_addr (head),
    .rd_data (rd_data)
  );

  assign count_out = count;

  // Next-state: flush wins; otherwise enqueue/dequeue (or bypass) update pointers and output.
  always_comb begin
    enq          = if_en_in && !full_out;
    deq          = dn_rdy_in && (count != '0);
`ifdef INST_BUFFER_BYPASS_EN
    bypass       = enq && dn_rdy_in && (count == '0);
`else
    bypass       = 1'b0;
`endif
    wr_en        = 1'b0;
    head_nxt     = head;
    tail_nxt     = tail;
    count_nxt    = count;
    dec_en_nxt   = dec_en_out;
    dec_inst_nxt = dec_inst_out;
    dec_pc_nxt   = dec_pc_out;

    if (rdy_in) begin
      if (flush_in) begin
        head_nxt   = '0;
        tail_nxt   = '0;
        count_nxt  = '0;
        dec_en_nxt = 1'b0;
      end else begin
        dec_en_nxt = deq || bypass;
        if (enq && !bypass) begin
          wr_en    = 1'b1;
          tail_nxt = tail + PTR_W'(1);
        end
        if (deq) begin
          head_nxt                   = head + PTR_W'(1);
          {dec_inst_nxt, dec_pc_nxt} = rd_data;
        end else if (bypass) begin
          dec_inst_nxt = if_inst_in;
          dec_pc_nxt   = if_pc_in;
        end
        count_nxt = count + CNT_W'(enq && !bypass) - CNT_W'(deq);
      end
    end

    full_nxt  = (count_nxt == CNT_W'(DEPTH));
    afull_nxt = (count_nxt >= CNT_W'(AFULL_THRESH));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      full_out        <= 1'b0;
      almost_full_out <= 1'b0;
      dec_en_out      <= 1'b0;
      dec_inst_out    <= INST_W'(`NOP);
      dec_pc_out      <= '0;
    end else begin
      head            <= head_nxt;
      tail            <= tail_nxt;
      count           <= count_nxt;
      full_out        <= full_nxt;
      almost_full_out <= afull_nxt;
      dec_en_out      <= dec_en_nxt;
      dec_inst_out    <= dec_inst_nxt;
      dec_pc_out      <= dec_pc_nxt;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: reference queue scoreboard plus a hand-written vector table.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

module tb_inst_buffer;
  localparam int DEPTH = 16;
`ifdef INST_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, if_en_in, dn_rdy_in;
  logic [31:0] if_inst_in, if_pc_in;
  logic        full_out, almost_full_out, dec_en_out;
  logic [4:0]  count_out;
  logic [31:0] dec_inst_out, dec_pc_out;

  inst_buffer #(
    .DEPTH(16), .PTR_W(4), .INST_W(32), .PC_W(32), .AFULL_THRESH(12)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_en_in(if_en_in), .if_inst_in(if_inst_in), .if_pc_in(if_pc_in),
    .full_out(full_out), .almost_full_out(almost_full_out), .count_out(count_out),
    .dn_rdy_in(dn_rdy_in), .dec_en_out(dec_en_out),
    .dec_inst_out(dec_inst_out), .dec_pc_out(dec_pc_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic rdy, flush, en, dn;
    int   exp_count;
    logic exp_en;
  } vec_t;

  ent_t sb[$];
  ent_t mlast;
  logic men;
  int   seq;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    men        = 1'b0;
    mlast.inst = `NOP;
    mlast.pc   = 32'h0;
  endtask

  // One clock: drive at negedge, update model, compare #1 after the rising edge.
  task automatic step(input logic rdy, input logic flush, input logic en, input logic dn);
    ent_t e;
    logic enq, deq, byp;
    @(negedge clk_in);
    e.inst     = 32'hA500_0000 | 32'(seq);
    e.pc       = 32'(seq * 4);
    rdy_in     = rdy;
    flush_in   = flush;
    if_en_in   = en;
    dn_rdy_in  = dn;
    if_inst_in = e.inst;
    if_pc_in   = e.pc;
    if (rdy) begin
      if (flush) begin
        sb.delete();
        men = 1'b0;
      end else begin
        enq = en && (sb.size() != DEPTH);
        deq = dn && (sb.size() != 0);
        byp = BYP && enq && dn && (sb.size() == 0);
        men = deq || byp;
        if (deq) mlast = sb.pop_front();
        else if (byp) mlast = e;
        if (enq && !byp) sb.push_back(e);
        if (enq) seq++;
      end
    end
    @(posedge clk_in);
    #1;
    chk("count", 64'(count_out), 64'(sb.size()));
    chk("full", 64'(full_out), 64'(sb.size() == DEPTH));
    chk("afull", 64'(almost_full_out), 64'(sb.size() >= 12));
    chk("dec_en", 64'(dec_en_out), 64'(men));
    chk("dec_inst", 64'(dec_inst_out), 64'(mlast.inst));
    chk("dec_pc", 64'(dec_pc_out), 64'(mlast.pc));
  endtask

  vec_t tbl[12];
  int   lat;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};

    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; if_en_in = 1'b0; dn_rdy_in = 1'b0;
    if_inst_in = '0; if_pc_in = '0;
    seq = 0;
    model_reset();
    #12;
    chk("rst_count", 64'(count_out), 64'(0));
    chk("rst_dec_en", 64'(dec_en_out), 64'(0));
    chk("rst_inst", 64'(dec_inst_out), 64'(`NOP));
    chk("rst_pc", 64'(dec_pc_out), 64'(0));
    rst_in = 1'b0;

    // Reset mid-stream, asserted between edges and checked before the next edge.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk_in);
    if_en_in = 1'b0; dn_rdy_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst_count", 64'(count_out), 64'(0));
    chk("async_rst_dec_en", 64'(dec_en_out), 64'(0));
    chk("async_rst_full", 64'(full_out), 64'(0));
    chk("async_rst_pc", 64'(dec_pc_out), 64'(0));
    #1 rst_in = 1'b0;
    model_reset();

    // Vector table: enqueue/dequeue, rdy freeze, flush with enqueue at count 5.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rdy, tbl[i].flush, tbl[i].en, tbl[i].dn);
      chk("tbl_count", 64'(count_out), 64'(tbl[i].exp_count));
      chk("tbl_dec_en", 64'(dec_en_out), 64'(tbl[i].exp_en));
    end

    // Fill with dn_rdy_in low, then one dropped enqueue.
    seq = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("fill_afull", 64'(almost_full_out), 64'(i >= 12));
      chk("fill_full", 64'(full_out), 64'(i == 16));
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("fill_drop_count", 64'(count_out), 64'(16));

    // Drain in order.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("drain_en", 64'(dec_en_out), 64'(1));
      chk("drain_pc", 64'(dec_pc_out), 64'(k * 4));
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("drain_end_en", 64'(dec_en_out), 64'(0));
    chk("drain_end_count", 64'(count_out), 64'(0));

    // Interleaved traffic with toggling dn_rdy_in, crossing the 15->0 pointer wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, (i % 3) != 2, i[0]);
    end
    for (int k = 0; k < 40 && sb.size() != 0; k++) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Full with a simultaneous dequeue: enqueue still refused that cycle.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("full_deq_count", 64'(count_out), 64'(15));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("full_refill_count", 64'(count_out), 64'(16));
    for (int k = 0; k < 40 && sb.size() != 0; k++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Single enqueue into an empty buffer: latency from if_en_in to dec_en_out.
    lat = 0;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    if (dec_en_out) lat = 1;
    for (int k = 2; k <= 4 && lat == 0; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (dec_en_out) lat = k;
    end
    chk("latency", 64'(lat), BYP ? 64'(1) : 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
